// File: rtl/ones_gen_pkg.sv
// Shared definitions for the ones-pattern generator: FSM state encoding and a
// ceiling-log2 helper used to size the count input.
package ones_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Smallest r with 2**r >= v.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/ones_pattern_gen_lsb_index.sv
// lsb_index: combinational trailing-zero counter. Returns the index of the
// lowest set bit of x, or N when x is zero.
module lsb_index
   import ones_gen_pkg::*;
#(
   parameter int unsigned N  = 9,
   parameter int unsigned CW = clog2(N + 1)
) (
   input  logic [N-1:0]  x,
   output logic [CW-1:0] tz
);

   // Scan from MSB down so the lowest set bit wins.
   always_comb begin
      tz = CW'(N);
      for (int unsigned i = 0; i < N; i++) begin
         if (x[N-1-i]) tz = CW'(N - 1 - i);
      end
   end

endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: enumerates every N-bit word with exactly k bits set, in
// ascending numeric order, one word per ready/valid handshake.
// Optional build macro POPCOUNT_CHECK_EN adds a sticky chk_err output that
// flags any presented word whose popcount differs from the latched k.
module ones_pattern_gen
   import ones_gen_pkg::*;
#(
   parameter int unsigned N  = 9,
   parameter int unsigned CW = clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] k,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  pattern,
   output logic          last,
   output logic          done,
   output logic          err
`ifdef POPCOUNT_CHECK_EN
   ,
   output logic          chk_err
`endif
);

   state_e        state_q, state_d;
   logic [CW-1:0] k_q, k_d;
   logic [N-1:0]  pattern_q, pattern_d;
   logic          err_q, err_d;

   logic [N-1:0]  lsb, sum, next_word;
   logic [CW-1:0] tz;
   logic          k_bad, start_ok, at_last;

   // Lowest k bits set: first word of an enumeration.
   function automatic logic [N-1:0] ones_low(input logic [CW-1:0] cnt);
      logic [N-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (i < 32'(cnt)) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Highest k bits set: final word of an enumeration.
   function automatic logic [N-1:0] ones_high(input logic [CW-1:0] cnt);
      logic [N-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (i + 32'(cnt) >= N) m[i] = 1'b1;
      end
      return m;
   endfunction

   lsb_index #(
      .N  (N),
      .CW (CW)
   ) u_lsb_index (
      .x  (pattern_q),
      .tz (tz)
   );

   // Next-combination step: move lowest run of ones up, repack the rest at LSBs.
   always_comb begin
      lsb       = pattern_q & (~pattern_q + 1'b1);
      sum       = pattern_q + lsb;
      next_word = sum | (((pattern_q ^ sum) >> 2) >> tz);
      at_last   = (pattern_q == ones_high(k_q));
      k_bad     = (k > CW'(N));
      start_ok  = (state_q == ST_IDLE) && start && !k_bad;
   end

   // Next-state and datapath update; start is only honoured in IDLE.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      pattern_d = pattern_q;
      err_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (k_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d   = ST_GEN;
                  k_d       = k;
                  pattern_d = ones_low(k);
               end
            end
         end
         ST_GEN: begin
            if (out_ready) begin
               if (at_last) state_d = ST_DONE;
               else         pattern_d = next_word;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched count, current word and error pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         pattern_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         pattern_q <= pattern_d;
         err_q     <= err_d;
      end
   end

   // Outputs decode directly from registered state.
   always_comb begin
      busy      = (state_q == ST_GEN);
      out_valid = (state_q == ST_GEN);
      last      = (state_q == ST_GEN) && at_last;
      done      = (state_q == ST_DONE);
      err       = err_q;
      pattern   = pattern_q;
   end

`ifdef POPCOUNT_CHECK_EN
   logic          chk_err_q, chk_err_d;
   logic [CW-1:0] pop;

   // Sticky popcount monitor on presented words; an accepted start clears it.
   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pop = pop + CW'(pattern_q[i]);
      end
      chk_err_d = chk_err_q;
      if (start_ok)                                  chk_err_d = 1'b0;
      else if ((state_q == ST_GEN) && (pop != k_q))  chk_err_d = 1'b1;
   end

   // Checker flag register.
   always_ff @(posedge clk) begin
      if (rst) chk_err_q <= 1'b0;
      else     chk_err_q <= chk_err_d;
   end

   assign chk_err = chk_err_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed testbench for ones_pattern_gen (N=9): table of enumeration runs
// plus hand-written error, stall, reset and start-while-busy sequences.
module tb_ones_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] k;
   logic       busy, out_valid, out_ready, last, done, err;
   logic [8:0] pattern;
`ifdef POPCOUNT_CHECK_EN
   logic       chk_err;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [8:0]  words[$];

   typedef struct {
      logic [3:0]  k;
      int unsigned n;
      logic [8:0]  first;
      logic [8:0]  second;
      logic [8:0]  lastw;
   } vec_t;

   vec_t vt[8];

   ones_pattern_gen #(
      .N  (9),
      .CW (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k         (k),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pattern   (pattern),
      .last      (last),
      .done      (done),
      .err       (err)
`ifdef POPCOUNT_CHECK_EN
      ,
      .chk_err   (chk_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start an enumeration, drain it, and verify the collected word list.
   task automatic run_vec(input vec_t v, input bit stall, input int inj_cyc, input logic [3:0] inj_k);
      logic [8:0]  prev;
      bit          prev_stalled, got_last, rdy, asc_ok, pop_ok;
      int unsigned cyc;
      words.delete();
      prev = '0;
      prev_stalled = 1'b0;
      got_last = 1'b0;
      cyc = 0;
      start = 1'b1;
      k = v.k;
      tick();
      start = 1'b0;
      check($sformatf("k%0d_first_valid", v.k), 16'({busy, out_valid}), 16'b11);
      while (!got_last && cyc < 3000) begin
         check($sformatf("k%0d_valid_hold", v.k), 16'(out_valid), 16'd1);
         if (prev_stalled) check($sformatf("k%0d_stall_hold", v.k), 16'(pattern), 16'(prev));
         check($sformatf("k%0d_last_flag", v.k), 16'(last), 16'(pattern == v.lastw));
         if (int'(cyc) == inj_cyc) begin
            start = 1'b1;
            k = inj_k;
         end else begin
            start = 1'b0;
         end
         if (stall) rdy = ((cyc % 10) < 3) ? 1'b0 : 1'($urandom_range(0, 1));
         else       rdy = 1'b1;
         out_ready = rdy;
         if (rdy) begin
            words.push_back(pattern);
            if (last) got_last = 1'b1;
         end
         prev = pattern;
         prev_stalled = !rdy;
         tick();
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      check($sformatf("k%0d_reached_last", v.k), 16'(got_last), 16'd1);
      check($sformatf("k%0d_done_pulse", v.k), 16'({out_valid, busy, done}), 16'b001);
      tick();
      check($sformatf("k%0d_done_clear", v.k), 16'({done, busy, out_valid}), 16'b000);
      check($sformatf("k%0d_count", v.k), 16'(words.size()), 16'(v.n));
      if (words.size() > 0) begin
         check($sformatf("k%0d_first_word", v.k), 16'(words[0]), 16'(v.first));
         check($sformatf("k%0d_last_word", v.k), 16'(words[words.size()-1]), 16'(v.lastw));
      end
      if (words.size() > 1)
         check($sformatf("k%0d_second_word", v.k), 16'(words[1]), 16'(v.second));
      asc_ok = 1'b1;
      pop_ok = 1'b1;
      for (int i = 0; i < words.size(); i++) begin
         if ($countones(words[i]) != int'(v.k)) pop_ok = 1'b0;
         if (i > 0 && words[i] <= words[i-1]) asc_ok = 1'b0;
      end
      check($sformatf("k%0d_popcount", v.k), 16'(pop_ok), 16'd1);
      check($sformatf("k%0d_ascending", v.k), 16'(asc_ok), 16'd1);
`ifdef POPCOUNT_CHECK_EN
      check($sformatf("k%0d_chk_err", v.k), 16'(chk_err), 16'd0);
`endif
   endtask

   initial begin
      vt[0] = '{k: 4'd0, n: 1,   first: 9'h000, second: 9'h000, lastw: 9'h000};
      vt[1] = '{k: 4'd1, n: 9,   first: 9'h001, second: 9'h002, lastw: 9'h100};
      vt[2] = '{k: 4'd2, n: 36,  first: 9'h003, second: 9'h005, lastw: 9'h180};
      vt[3] = '{k: 4'd3, n: 84,  first: 9'h007, second: 9'h00B, lastw: 9'h1C0};
      vt[4] = '{k: 4'd5, n: 126, first: 9'h01F, second: 9'h02F, lastw: 9'h1F0};
      vt[5] = '{k: 4'd8, n: 9,   first: 9'h0FF, second: 9'h17F, lastw: 9'h1FE};
      vt[6] = '{k: 4'd9, n: 1,   first: 9'h1FF, second: 9'h000, lastw: 9'h1FF};
      vt[7] = '{k: 4'd4, n: 126, first: 9'h00F, second: 9'h017, lastw: 9'h1E0};

      rst = 1'b1;
      start = 1'b0;
      k = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check("reset_outputs", 16'({busy, out_valid, last, done, err, pattern}), 16'd0);
      rst = 1'b0;
      tick();
      check("idle_outputs", 16'({busy, out_valid, last, done, err, pattern}), 16'd0);

      // Table runs with out_ready held high.
      for (int i = 0; i < 7; i++) run_vec(vt[i], 1'b0, -1, 4'd0);

      // Over-range k: one-cycle err, no run started; then a normal k=3 run.
      start = 1'b1;
      k = 4'd10;
      tick();
      start = 1'b0;
      check("err_pulse", 16'({err, busy, out_valid}), 16'b100);
      tick();
      check("err_clear", 16'({err, busy, out_valid}), 16'b000);
      run_vec(vt[3], 1'b0, -1, 4'd0);

      // k=4 with random backpressure and forced 3-cycle stalls.
      run_vec(vt[7], 1'b1, -1, 4'd0);

      // Reset while the 5th word of k=3 is presented.
      start = 1'b1;
      k = 4'd3;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("rst_fifth_word", 16'(pattern), 16'h013);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_outputs", 16'({busy, out_valid, last, done, err, pattern}), 16'd0);
      tick();
      check("rst_no_done", 16'({done, err, busy}), 16'd0);
      run_vec(vt[3], 1'b0, -1, 4'd0);

      // Start with a different k while busy must be ignored.
      run_vec(vt[2], 1'b0, 5, 4'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
